// File: rtl/bcd_digit_entry_pkg.sv
// Shared definitions for the keypad digit-entry controller: key codes,
// FSM state encoding and key classification.
package bcd_digit_entry_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ENTRY  = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    KC_DIGIT   = 2'd0,
    KC_CLEAR   = 2'd1,
    KC_ENTER   = 2'd2,
    KC_ILLEGAL = 2'd3
  } key_class_e;

  function automatic logic is_digit(input logic [3:0] code);
    return code <= 4'd9;
  endfunction

  // A-D are the only codes that fall through to KC_ILLEGAL.
  function automatic key_class_e classify_key(input logic [3:0] code);
    if (is_digit(code))          return KC_DIGIT;
    else if (code == KEY_CLEAR)  return KC_CLEAR;
    else if (code == KEY_ENTER)  return KC_ENTER;
    else                         return KC_ILLEGAL;
  endfunction

endpackage

// File: rtl/bcd_digit_entry_timer.sv
// Idle timer for the ENTRY state: down-counter reloaded on restart or while
// not running, with a terminal-count compare producing a one-cycle expired pulse.
module entry_timer #(
  parameter int TIMEOUT = 50000000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LOAD = CW'(TIMEOUT);

  logic [CW-1:0] cnt_q;

  // Count parks at zero after firing so the pulse cannot repeat; TIMEOUT=0 never reaches one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= LOAD;
    end else if (restart || !run) begin
      cnt_q <= LOAD;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign expired = run && (cnt_q == CW'(1));

endmodule

// File: rtl/bcd_digit_entry.sv
// Keypad digit-entry controller driving the a/en inputs of a bank of 4-bit
// digit registers; handles clear, enter/lock, overflow and idle timeout.
//
// state     | meaning
// ST_IDLE   | nothing entered, pos 0
// ST_ENTRY  | 1..NUM_DIGITS digits entered, idle timer running
// ST_LOCKED | entry accepted, keys rejected until unlock
module bcd_digit_entry #(
  parameter int NUM_DIGITS = 4,
  parameter int TIMEOUT    = 50000000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_valid,
  input  logic [3:0]                        key_code,
  input  logic                              unlock,
  output logic [3:0]                        d_data,
  output logic [NUM_DIGITS-1:0]             d_en,
  output logic [$clog2(NUM_DIGITS+1)-1:0]   pos,
  output logic                              locked,
  output logic                              done,
  output logic                              err
);

  import bcd_digit_entry_pkg::*;

  localparam int PW = $clog2(NUM_DIGITS + 1);
  localparam logic [NUM_DIGITS-1:0] EN_ONE   = NUM_DIGITS'(1);
  localparam logic [PW-1:0]         POS_FULL = PW'(NUM_DIGITS);

  state_e                  state_q;
  logic [3:0]              d_data_q;
  logic [NUM_DIGITS-1:0]   d_en_q;
  logic [PW-1:0]           pos_q;
  logic                    locked_q;
  logic                    done_q;
  logic                    err_q;

  key_class_e              kc;
  logic                    in_entry;
  logic                    tmr_expired;

  assign kc       = classify_key(key_code);
  assign in_entry = (state_q == ST_ENTRY);

  entry_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .run     (in_entry),
    .restart (key_valid),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      d_data_q <= '0;
      d_en_q   <= '0;
      pos_q    <= '0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      d_en_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (key_valid) begin
            case (kc)
              KC_DIGIT: begin
                d_en_q   <= EN_ONE;
                d_data_q <= key_code;
                pos_q    <= PW'(1);
                state_q  <= ST_ENTRY;
              end
              KC_CLEAR: begin
                d_en_q   <= '1;
                d_data_q <= '0;
                pos_q    <= '0;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        ST_ENTRY: begin
          // A key in the same cycle as the timer firing takes priority.
          if (key_valid) begin
            case (kc)
              KC_DIGIT: begin
                if (pos_q < POS_FULL) begin
                  d_en_q   <= EN_ONE << pos_q;
                  d_data_q <= key_code;
                  pos_q    <= pos_q + PW'(1);
                end else begin
                  err_q <= 1'b1;
                end
              end
              KC_CLEAR: begin
                d_en_q   <= '1;
                d_data_q <= '0;
                pos_q    <= '0;
                state_q  <= ST_IDLE;
              end
              KC_ENTER: begin
                done_q   <= 1'b1;
                locked_q <= 1'b1;
                state_q  <= ST_LOCKED;
              end
              default: err_q <= 1'b1;
            endcase
          end else if (tmr_expired) begin
            d_en_q   <= '1;
            d_data_q <= '0;
            pos_q    <= '0;
            state_q  <= ST_IDLE;
          end
        end
        ST_LOCKED: begin
          if (unlock) begin
            locked_q <= 1'b0;
            pos_q    <= '0;
            state_q  <= ST_IDLE;
          end else if (key_valid) begin
            err_q <= 1'b1;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          pos_q    <= '0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign d_data = d_data_q;
  assign d_en   = d_en_q;
  assign pos    = pos_q;
  assign locked = locked_q;
  assign done   = done_q;
  assign err    = err_q;

endmodule

// File: tb/tb_bcd_digit_entry.sv
// Bench for bcd_digit_entry: directed keypad scenarios followed by random key
// streams, checked against a behavioural model of the entry rules.
module tb_bcd_digit_entry;

  localparam int ND = 4;
  localparam int TO = 10;
  localparam int PW = $clog2(ND + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           key_valid = 1'b0;
  logic [3:0]     key_code = 4'd0;
  logic           unlock = 1'b0;
  logic [3:0]     d_data;
  logic [ND-1:0]  d_en;
  logic [PW-1:0]  pos;
  logic           locked;
  logic           done;
  logic           err;

  bcd_digit_entry #(
    .NUM_DIGITS (ND),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_valid (key_valid),
    .key_code  (key_code),
    .unlock    (unlock),
    .d_data    (d_data),
    .d_en      (d_en),
    .pos       (pos),
    .locked    (locked),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Downstream reg_4b bank, sharing the controller's reset net.
  logic [3:0] regs [ND];
  always @(posedge clk or negedge rst) begin
    for (int i = 0; i < ND; i++) begin
      if (!rst)          regs[i] <= 4'd0;
      else if (d_en[i])  regs[i] <= d_data;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: digits entered so far, lock flag, idle cycles since last key.
  int             m_count;
  bit             m_locked;
  int             m_idle;
  logic [3:0]     mem   [ND];
  logic [3:0]     mem_a [ND];
  logic [3:0]     mem_b [ND];
  logic [ND-1:0]  e_en;
  logic [3:0]     e_data;
  logic           e_done;
  logic           e_err;

  function automatic void model_clear();
    e_en    = '1;
    e_data  = 4'd0;
    m_count = 0;
    for (int i = 0; i < ND; i++) mem[i] = 4'd0;
  endfunction

  function automatic void model_reset();
    m_count  = 0;
    m_locked = 0;
    m_idle   = 0;
    e_en     = '0;
    e_data   = 4'd0;
    e_done   = 0;
    e_err    = 0;
    for (int i = 0; i < ND; i++) begin
      mem[i] = 4'd0; mem_a[i] = 4'd0; mem_b[i] = 4'd0;
    end
  endfunction

  function automatic void model_step(input logic kv, input logic [3:0] code, input logic ul);
    e_en   = '0;
    e_done = 0;
    e_err  = 0;
    if (m_locked) begin
      m_idle = 0;
      if (ul) begin
        m_locked = 0;
        m_count  = 0;
      end else if (kv) begin
        e_err = 1;
      end
    end else if (kv) begin
      m_idle = 0;
      if (code <= 4'd9) begin
        if (m_count < ND) begin
          e_en         = ND'(1) << m_count;
          e_data       = code;
          mem[m_count] = code;
          m_count++;
        end else begin
          e_err = 1;
        end
      end else if (code == 4'hE) begin
        model_clear();
      end else if (code == 4'hF) begin
        if (m_count == 0) e_err = 1;
        else begin
          e_done   = 1;
          m_locked = 1;
        end
      end else begin
        e_err = 1;
      end
    end else if (m_count > 0 && TO != 0) begin
      if (m_idle + 1 == TO) begin
        model_clear();
        m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  endfunction

  task automatic compare_outputs();
    check_val("d_en", d_en, e_en);
    if (e_en != '0) check_val("d_data", d_data, e_data);
    check_val("pos", pos, m_count);
    check_val("locked", locked, m_locked);
    check_val("done", done, e_done);
    check_val("err", err, e_err);
    for (int i = 0; i < ND; i++) check_val("reg", regs[i], mem_b[i]);
  endtask

  task automatic step(input logic kv, input logic [3:0] code, input logic ul);
    @(negedge clk);
    compare_outputs();
    key_valid = kv;
    key_code  = code;
    unlock    = ul;
    model_step(kv, code, ul);
    mem_b = mem_a;
    mem_a = mem;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'd0, 1'b0);
  endtask

  task automatic reset_now();
    rst       = 1'b0;
    key_valid = 1'b0;
    unlock    = 1'b0;
    #1;
    check_val("rst_d_en", d_en, 0);
    check_val("rst_d_data", d_data, 0);
    check_val("rst_pos", pos, 0);
    check_val("rst_locked", locked, 0);
    check_val("rst_done", done, 0);
    check_val("rst_err", err, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic reset_mid();
    @(posedge clk);
    #2;
    reset_now();
  endtask

  logic [3:0] rcode;
  int         pct;

  initial begin
    #3;
    reset_now();

    for (int k = 1; k <= 4; k++) step(1'b1, 4'(k), 1'b0);
    idle(3);
    check_val("pos_full", pos, 4);
    for (int i = 0; i < ND; i++) check_val("reg_seq", regs[i], i + 1);

    step(1'b1, 4'd5, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    idle(1);
    check_val("locked_after_enter", locked, 1);
    step(1'b1, 4'd7, 1'b0);
    step(1'b0, 4'd0, 1'b1);
    step(1'b1, 4'd9, 1'b0);
    idle(2);
    check_val("reg0_after_unlock", regs[0], 9);

    step(1'b1, 4'd3, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'hE, 1'b0);
    idle(2);
    check_val("pos_after_clear", pos, 0);

    step(1'b1, 4'd6, 1'b0);
    idle(12);
    check_val("pos_after_timeout", pos, 0);
    step(1'b1, 4'd6, 1'b0);
    idle(8);
    step(1'b1, 4'd2, 1'b0);
    idle(9);
    check_val("pos_no_timeout", pos, 2);
    step(1'b1, 4'hA, 1'b0);
    step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'd3, 1'b1);
    step(1'b1, 4'hF, 1'b0);
    step(1'b1, 4'd4, 1'b0);
    step(1'b1, 4'd5, 1'b0);
    reset_mid();
    idle(2);

    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) pct = ($urandom_range(0, 1) == 0) ? 40 : 8;
      if (n % 1500 == 777) begin
        step(1'b1, 4'd1, 1'b0);
        reset_mid();
      end
      case ($urandom_range(0, 9))
        7:       rcode = 4'hE;
        8:       rcode = 4'hF;
        9:       rcode = 4'hA + 4'($urandom_range(0, 3));
        default: rcode = 4'($urandom_range(0, 9));
      endcase
      step(($urandom_range(0, 99) < pct) ? 1'b1 : 1'b0, rcode,
           ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
